// File: rtl/counter_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// cnt_sched_pkg
//
// Purpose : shared definitions for the counter_scheduler block and its
//           round-robin arbiter.
// Contents:
//   CNT_SCHED_NREQ   default number of requesters sharing the counter
//   CNT_SCHED_WIDTH  default counter / length width in bits
//   state_t          scheduler FSM state encoding
//   idx_width()      width of a requester index (never below 1 bit)
// ---------------------------------------------------------------------------
package cnt_sched_pkg;

    localparam int unsigned CNT_SCHED_NREQ  = 4;
    localparam int unsigned CNT_SCHED_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    // A single requester still needs a 1-bit index signal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : cnt_sched_pkg

// File: rtl/counter_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purpose : purely combinational round-robin pick. The winner is the first
//           set request bit at or after ptr+1, wrapping modulo NREQ, so the
//           requester named by ptr has the lowest priority.
// Ports   :
//   req        [NREQ-1:0]  request vector
//   ptr        [IDXW-1:0]  index of the most recently served requester
//   grant      [NREQ-1:0]  one-hot winner, zero when no request is set
//   grant_idx  [IDXW-1:0]  binary index of the winner (0 when none)
//   valid                  at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter
    import cnt_sched_pkg::*;
#(
    parameter  int unsigned NREQ = CNT_SCHED_NREQ,
    localparam int unsigned IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            valid
);

    // (base + off) mod NREQ, truncated to an index.
    function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = (32'(base) + off) % NREQ;
        return sum[IDXW-1:0];
    endfunction

    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        // Offsets 1..NREQ visit ptr+1 first and ptr itself last.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!valid && req[wrap_idx(ptr, i)]) begin
                valid     = 1'b1;
                grant_idx = wrap_idx(ptr, i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            grant[j] = valid && (grant_idx == IDXW'(j));
        end
    end

endmodule : rr_arbiter

// File: rtl/counter_scheduler.sv
// ---------------------------------------------------------------------------
// counter_scheduler
//
// Purpose : shares one up-counter among NREQ requesters. An idle scheduler
//           picks a requester round-robin, captures its target length,
//           counts enable-qualified ticks up to that length, then pulses
//           done with the owner's index and returns to idle.
//
// Optional feature (macro CNT_SCHED_ABORT_EN):
//   defined   - the owner dropping its req while the count runs abandons
//               the run: aborted pulses for one cycle, no done.
//   undefined - req is ignored once granted; aborted is constant 0.
//
// Ports:
//   clk       clock, all state on the rising edge
//   clrn      asynchronous active-low reset
//   enable    count-tick qualifier
//   req       [NREQ-1:0]        level requests, held until done/abort
//   len       [NREQ*WIDTH-1:0]  per-requester target, slice i = [i*WIDTH +: WIDTH]
//   gnt       [NREQ-1:0]        one-hot grant during LOAD and RUN
//   busy                        high during LOAD and RUN
//   count     [WIDTH-1:0]       shared counter value
//   done                        one-cycle completion pulse
//   done_id   [IDXW-1:0]        completed requester index while done=1
//   aborted                     one-cycle abandoned-run pulse
// ---------------------------------------------------------------------------
module counter_scheduler
    import cnt_sched_pkg::*;
#(
    parameter  int unsigned NREQ  = CNT_SCHED_NREQ,
    parameter  int unsigned WIDTH = CNT_SCHED_WIDTH,
    localparam int unsigned IDXW  = idx_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  enable,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic                  done,
    output logic [IDXW-1:0]       done_id,
    output logic                  aborted
);

    state_t            state;
    state_t            state_nxt;

    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   win_idx;
    logic [WIDTH-1:0]  len_q;

    logic [NREQ-1:0]   arb_grant;
    logic [IDXW-1:0]   arb_idx;
    logic              arb_valid;
    logic [WIDTH-1:0]  len_sel;
    logic [WIDTH-1:0]  count_inc;
    logic              abort_now;

    // -----------------------------------------------------------------------
    // Arbitration and length selection (only consumed in IDLE)
    // -----------------------------------------------------------------------
    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_comb begin
        len_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                len_sel = len[i*WIDTH +: WIDTH];
            end
        end
    end

    // count never exceeds len_q (at most 2^WIDTH-1), so this cannot wrap
    // on any increment that is actually committed.
    assign count_inc = count + WIDTH'(1);

`ifdef CNT_SCHED_ABORT_EN
    assign abort_now = (state == ST_RUN) && !req[win_idx];
`else
    assign abort_now = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = (len_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (abort_now) begin
                    state_nxt = ST_IDLE;
                end else if (enable && (count_inc == len_q)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from the registered state and owner index
    // -----------------------------------------------------------------------
    always_comb begin
        busy    = (state == ST_LOAD) || (state == ST_RUN);
        done    = (state == ST_DONE);
        done_id = (state == ST_DONE) ? win_idx : '0;
        gnt     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            gnt[i] = busy && (win_idx == IDXW'(i));
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: owner capture, shared counter, round-robin pointer, abort
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            // ptr starts at the last requester so requester 0 wins first.
            ptr     <= IDXW'(NREQ - 1);
            win_idx <= '0;
            len_q   <= '0;
            count   <= '0;
            aborted <= 1'b0;
        end else begin
            aborted <= abort_now;
            case (state)
                ST_IDLE: begin
                    // Owner and length are frozen here; later req/len
                    // changes cannot disturb the run.
                    if (arb_valid) begin
                        win_idx <= arb_idx;
                        len_q   <= len_sel;
                    end
                end
                ST_LOAD: begin
                    count <= '0;
                end
                ST_RUN: begin
                    // An abandoned run still rotates priority past its owner;
                    // the counter keeps its last value.
                    if (abort_now) begin
                        ptr <= win_idx;
                    end else if (enable) begin
                        count <= count_inc;
                    end
                end
                ST_DONE: begin
                    ptr <= win_idx;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : counter_scheduler

// File: doc/counter_scheduler.md
COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the counter.
REQ-002 Parameter WIDTH, default 4: counter and length width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port clrn, input, 1: reset, asynchronous, active-low.
REQ-005 Port enable, input, 1: count-tick qualifier; the counter advances only on cycles with enable=1.
REQ-006 Port req, input, NREQ: per-requester level request, held until done or abort.
REQ-007 Port len, input, NREQ*WIDTH: per-requester target count; slice i is bits [i*WIDTH +: WIDTH].
REQ-008 Port gnt, output, NREQ: one-hot registered grant; all zero when no requester owns the counter.
REQ-009 Port busy, output, 1: high in LOAD and RUN.
REQ-010 Port count, output, WIDTH: current shared counter value.
REQ-011 Port done, output, 1: one-cycle pulse when the owner's count completes.
REQ-012 Port done_id, output, $clog2(NREQ): index of the completed requester; valid while done=1.
REQ-013 Port aborted, output, 1: one-cycle pulse when a run is abandoned.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, DONE.
REQ-015 IDLE: if any req bit is set, round-robin winner = first set bit at or after ptr+1 (mod NREQ); capture winner index and its len slice; go to LOAD. Otherwise stay in IDLE.
REQ-016 LOAD: gnt[winner]=1, busy=1, count<=0; if captured len==0 go to DONE, else go to RUN.
REQ-017 RUN: if enable=1, count<=count+1; if count+1==captured len, go to DONE; if enable=0, count holds.
REQ-018 DONE: done=1, done_id=winner, gnt=0, busy=0; ptr<=winner; count holds its final value; go to IDLE.
REQ-019 Latency: with enable held at 1, req sampled in IDLE at cycle t gives done at t+2+len, or at t+2 when len=0.
REQ-020 count never wraps, because len is at most 2^WIDTH-1; count holds in IDLE until the next LOAD.
REQ-021 Changes to req or len during LOAD, RUN or DONE do not alter the captured length or winner, except as defined by REQ-026.
REQ-022 Requests that arrive while busy wait; no request is lost while its req stays high.
REQ-023 Fairness: with all req high, grants rotate 0,1,2,...,NREQ-1,0.

Reset
REQ-024 While clrn=0, asynchronously: state=IDLE, ptr=NREQ-1 (so requester 0 wins first), count=0, gnt=0, busy=0, done=0, done_id=0, aborted=0.
REQ-025 A reset asserted mid-run discards the run, with no done and no aborted pulse.

Configuration
REQ-026 With CNT_SCHED_ABORT_EN defined: req[winner]=0 sampled in RUN gives aborted=1 for one cycle with gnt=0 and ptr<=winner, then IDLE; done stays 0.
REQ-027 Without CNT_SCHED_ABORT_EN: req is ignored once granted, the run always reaches DONE, and aborted is tied to 0. The port remains present.

Structure
REQ-028 Shared package cnt_sched_pkg holds the state enum type and the default NREQ and WIDTH constants.
REQ-029 One sub-module, rr_arbiter (req, ptr -> one-hot winner and index), is combinational and is instantiated once.

Verification
REQ-030 Reset, then req=4'b0001, len0=3, enable=1: gnt=0001 for 4 cycles (LOAD and 3 RUN cycles), count steps 1,2,3, done at t+5 with done_id=0.
REQ-031 req=4'b1111, all len=1, enable=1: done_id sequence 0,1,2,3,0 and gnt is never multi-hot.
REQ-032 req0 with len0=0: LOAD then DONE, done at t+2, and count=0.
REQ-033 len0=2, enable toggling 1,0,1: count 1,1,2, done one cycle later than with enable held high.
REQ-034 With CNT_SCHED_ABORT_EN, drop req0 after count=1 (len0=5): aborted pulse, no done, next grant goes to requester 1 if it is requesting. Without the macro: done occurs at count=5.
REQ-035 clrn pulsed low during RUN at count=2: outputs clear immediately, no done, and the next grant goes to requester 0.
